// File: rtl/kp_gaussian_mac.sv
// 3x3 Gaussian blur MAC ([1 2 1;2 4 2;1 2 1]/16), three-stage pipeline with raster
// position tracking and frame/line markers on the output pixel.

module kp_gaussian_colsum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] top_i,
  input  logic [DATA_WIDTH-1:0] mid_i,
  input  logic [DATA_WIDTH-1:0] bot_i,
  output logic [DATA_WIDTH+1:0] sum_o
);
  assign sum_o = {2'b00, top_i} + {1'b0, mid_i, 1'b0} + {2'b00, bot_i};
endmodule

module kp_gaussian_mac #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 8,
  parameter int ROUND       = 1,
  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1,
  localparam int ROW_W = (LINE_COUNT  > 1) ? $clog2(LINE_COUNT)  : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [3*DATA_WIDTH-1:0] i_r0_data,
  input  logic [3*DATA_WIDTH-1:0] i_r1_data,
  input  logic [3*DATA_WIDTH-1:0] i_r2_data,
  input  logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  output logic [COL_W-1:0]        o_col,
  output logic [ROW_W-1:0]        o_row,
  output logic                    o_sol,
  output logic                    o_eol,
  output logic                    o_sof,
  output logic                    o_eof
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 3;
  localparam int W         = DATA_WIDTH;
  localparam int CS_W      = W + 2;
  localparam int ACC_W     = W + 4;
  localparam logic [ACC_W-1:0] RND_ADD = (ROUND != 0) ? ACC_W'(8) : '0;

  // Lane 2 is the left pixel, lane 0 the right, matching the input packing.
  logic [NUM_LANES-1:0][W-1:0]    r0, r1, r2;
  logic [NUM_LANES-1:0][CS_W-1:0] cs_d, cs_q;
  logic [ACC_W-1:0]               acc_d, acc_q, rnd;
  logic [W-1:0]                   pix_d, data_q;
  logic [STAGES:1]                vld_pipe;
  logic [COL_W-1:0]               col_d, col_q, ocol_q;
  logic [ROW_W-1:0]               row_d, row_q, orow_q;
  logic                           col_last, row_last;
  logic                           sol_d, eol_d, sof_d, eof_d;
  logic                           sol_q, eol_q, sof_q, eof_q;

  assign r0 = i_r0_data;
  assign r1 = i_r1_data;
  assign r2 = i_r2_data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    kp_gaussian_colsum #(.DATA_WIDTH(W)) u_cs (
      .top_i (r0[l]),
      .mid_i (r1[l]),
      .bot_i (r2[l]),
      .sum_o (cs_d[l])
    );
  end

  assign acc_d = {2'b00, cs_q[2]} + {1'b0, cs_q[1], 1'b0} + {2'b00, cs_q[0]};
  // acc + 8 peaks at 2^(W+4)-8, so the shifted value always fits in W bits.
  assign rnd   = acc_q + RND_ADD;
  assign pix_d = W'(rnd >> 4);

  // col_q/row_q hold the position the next valid output will carry.
  assign col_last = (col_q == COL_W'(LINE_LENGTH - 1));
  assign row_last = (row_q == ROW_W'(LINE_COUNT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vld_pipe[2]) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  assign sol_d = vld_pipe[2] && (col_q == '0);
  assign eol_d = vld_pipe[2] && col_last;
  assign sof_d = sol_d && (row_q == '0);
  assign eof_d = eol_d && row_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      cs_q     <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ocol_q   <= '0;
      orow_q   <= '0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
      if (i_valid)     cs_q  <= cs_d;
      if (vld_pipe[1]) acc_q <= acc_d;
      if (vld_pipe[2]) begin
        data_q <= pix_d;
        ocol_q <= col_q;
        orow_q <= row_q;
      end
      col_q <= col_d;
      row_q <= row_d;
      sol_q <= sol_d;
      eol_q <= eol_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = vld_pipe[STAGES];
  assign o_col   = ocol_q;
  assign o_row   = orow_q;
  assign o_sol   = sol_q;
  assign o_eol   = eol_q;
  assign o_sof   = sof_q;
  assign o_eof   = eof_q;
endmodule

// File: tb/tb_kp_gaussian_mac.sv
// Randomized bench for kp_gaussian_mac: three instances (default, truncating, 4x3 frame)
// share one stimulus stream and are scored against a per-cycle history model.

module tb_kp_gaussian_mac;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [23:0] i_r0_data = '0, i_r1_data = '0, i_r2_data = '0;

  logic [7:0] oa_data, ob_data, oc_data;
  logic       oa_valid, ob_valid, oc_valid;
  logic [9:0] oa_col, ob_col;
  logic [8:0] oa_row, ob_row;
  logic [1:0] oc_col, oc_row;
  logic       oa_sol, oa_eol, oa_sof, oa_eof;
  logic       ob_sol, ob_eol, ob_sof, ob_eof;
  logic       oc_sol, oc_eol, oc_sof, oc_eof;

  kp_gaussian_mac #(.LINE_LENGTH(640), .LINE_COUNT(480), .DATA_WIDTH(8), .ROUND(1)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_r0_data(i_r0_data), .i_r1_data(i_r1_data),
    .i_r2_data(i_r2_data), .i_valid(i_valid), .o_data(oa_data), .o_valid(oa_valid),
    .o_col(oa_col), .o_row(oa_row), .o_sol(oa_sol), .o_eol(oa_eol), .o_sof(oa_sof), .o_eof(oa_eof));

  kp_gaussian_mac #(.LINE_LENGTH(640), .LINE_COUNT(480), .DATA_WIDTH(8), .ROUND(0)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_r0_data(i_r0_data), .i_r1_data(i_r1_data),
    .i_r2_data(i_r2_data), .i_valid(i_valid), .o_data(ob_data), .o_valid(ob_valid),
    .o_col(ob_col), .o_row(ob_row), .o_sol(ob_sol), .o_eol(ob_eol), .o_sof(ob_sof), .o_eof(ob_eof));

  kp_gaussian_mac #(.LINE_LENGTH(4), .LINE_COUNT(3), .DATA_WIDTH(8), .ROUND(1)) dut_c (
    .i_clk(clk), .i_rst(i_rst), .i_r0_data(i_r0_data), .i_r1_data(i_r1_data),
    .i_r2_data(i_r2_data), .i_valid(i_valid), .o_data(oc_data), .o_valid(oc_valid),
    .o_col(oc_col), .o_row(oc_row), .o_sol(oc_sol), .o_eol(oc_eol), .o_sof(oc_sof), .o_eof(oc_eof));

  always #5 clk = ~clk;

  int  ncyc = 0;
  int  checks = 0, errors = 0;
  int  px[9];
  bit  hist_v[MAXC], hist_rst[MAXC];
  int  hist_px[MAXC][9];
  int  cnt[3], lcol[3], lrow[3], ldat[3];
  int  wgt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, ncyc);
    end
  endtask

  // Output at cycle n is the window presented in cycle n-3, unless a reset edge
  // fell anywhere in between; position is just the count of outputs since reset.
  task automatic model_check(input int id, input string nm, input int L, input int C,
                             input bit rnd, input logic ov, input logic [7:0] od,
                             input int oc, input int orw, input logic sol,
                             input logic eol, input logic sof, input logic eof);
    bit ev;
    int s, n3;
    n3 = ncyc - 3;
    ev = 1'b0;
    if (hist_rst[ncyc-1]) begin
      cnt[id] = 0; lcol[id] = 0; lrow[id] = 0; ldat[id] = 0;
    end else begin
      ev = hist_v[n3] && !hist_rst[n3] && !hist_rst[ncyc-2];
      if (ev) begin
        s = 0;
        for (int k = 0; k < 9; k++) s += wgt[k] * hist_px[n3][k];
        ldat[id] = (s + (rnd ? 8 : 0)) / 16;
        lcol[id] = cnt[id] % L;
        lrow[id] = (cnt[id] / L) % C;
        cnt[id]++;
      end
    end
    chk({nm, ".valid"}, int'(ov), int'(ev));
    chk({nm, ".data"}, int'(od), ldat[id]);
    chk({nm, ".col"}, oc, lcol[id]);
    chk({nm, ".row"}, orw, lrow[id]);
    chk({nm, ".sol"}, int'(sol), int'(ev && lcol[id] == 0));
    chk({nm, ".eol"}, int'(eol), int'(ev && lcol[id] == L - 1));
    chk({nm, ".sof"}, int'(sof), int'(ev && lcol[id] == 0 && lrow[id] == 0));
    chk({nm, ".eof"}, int'(eof), int'(ev && lcol[id] == L - 1 && lrow[id] == C - 1));
  endtask

  always @(negedge clk) begin
    if (ncyc >= 3 && ncyc < MAXC) begin
      model_check(0, "a", 640, 480, 1'b1, oa_valid, oa_data, int'(oa_col), int'(oa_row),
                  oa_sol, oa_eol, oa_sof, oa_eof);
      model_check(1, "b", 640, 480, 1'b0, ob_valid, ob_data, int'(ob_col), int'(ob_row),
                  ob_sol, ob_eol, ob_sof, ob_eof);
      model_check(2, "c", 4, 3, 1'b1, oc_valid, oc_data, int'(oc_col), int'(oc_row),
                  oc_sol, oc_eol, oc_sof, oc_eof);
    end
  end

  task automatic apply(input bit v, input bit r);
    i_valid   = v;
    i_rst     = r;
    i_r0_data = {8'(px[0]), 8'(px[1]), 8'(px[2])};
    i_r1_data = {8'(px[3]), 8'(px[4]), 8'(px[5])};
    i_r2_data = {8'(px[6]), 8'(px[7]), 8'(px[8])};
    hist_v[ncyc]   = v;
    hist_rst[ncyc] = r;
    for (int k = 0; k < 9; k++) hist_px[ncyc][k] = px[k];
  endtask

  task automatic drive(input bit v, input bit r);
    @(negedge clk);
    apply(v, r);
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < 9; k++) px[k] = val;
  endtask

  task automatic rand_px();
    for (int k = 0; k < 9; k++) px[k] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0);
  endtask

  initial begin
    set_all(0);
    apply(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);

    // Directed kernels: saturated window, centre, corner and edge taps
    set_all(255);             drive(1'b1, 1'b0);
    idle(3);
    set_all(0); px[4] = 10;   drive(1'b1, 1'b0);
    set_all(0); px[0] = 160;  drive(1'b1, 1'b0);
    set_all(0); px[5] = 80;   drive(1'b1, 1'b0);
    idle(3);

    // Back-to-back burst with a gap
    for (int k = 0; k < 6; k++) begin rand_px(); drive(1'b1, 1'b0); end
    idle(2);
    for (int k = 0; k < 3; k++) begin rand_px(); drive(1'b1, 1'b0); end
    idle(4);

    // Two full 4x3 frames with random gaps from a clean reset
    drive(1'b0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      rand_px(); drive(1'b1, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(4);

    // Reset with two windows in flight
    rand_px(); drive(1'b1, 1'b0);
    rand_px(); drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    rand_px(); drive(1'b1, 1'b0);
    idle(4);

    // Long random run wrapping the small frame several times
    for (int k = 0; k < 300; k++) begin
      rand_px();
      drive($urandom_range(0, 3) != 0, 1'b0);
    end
    idle(5);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
